coproc_frame_ctrl: RTL

- Byte-level sequencer in front of the UART coprocessor datapath.
- Collects a command byte plus a payload from the UART RX byte stream and packs the payload into a WIDTH_DIN word.
- Drives the coprocessor's din, din_valid and control[5:0], waits for dout_valid, then serializes the WIDTH_DOUT result back to the UART TX byte stream with ready/valid backpressure.
- One frame in flight at a time.

---
 rtl/coproc_frame_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/coproc_frame_ctrl.sv
// Byte-level frame sequencer between the UART byte streams and the coprocessor.
// Accepts a command byte followed by NIN payload bytes and packs the payload
// MSB-first into cp_din. It then pulses cp_din_valid and waits (bounded) for
// cp_dout_valid. The result is returned as NOUT bytes under tx ready/valid.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rx_byte, rx_valid   received byte stream (one-cycle strobes)
//   tx_byte, tx_valid,  transmit byte stream with backpressure
//   tx_ready
//   cp_din, cp_din_valid, cp_control   coprocessor request
//   cp_dout, cp_dout_valid             coprocessor response
//   busy                not IDLE
//   err_timeout         sticky, response never arrived
//   err_drop            sticky, an RX byte arrived while a frame was in flight
module coproc_frame_ctrl #(
    parameter int unsigned WIDTH_DIN  = 144,
    parameter int unsigned WIDTH_DOUT = 144,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [WIDTH_DIN-1:0]  cp_din,
    output logic                  cp_din_valid,
    output logic [5:0]            cp_control,
    input  logic [WIDTH_DOUT-1:0] cp_dout,
    input  logic                  cp_dout_valid,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_drop
);

    localparam int unsigned NIN   = WIDTH_DIN / 8;
    localparam int unsigned NOUT  = WIDTH_DOUT / 8;
    localparam int unsigned NMAX  = (NIN > NOUT) ? NIN : NOUT;
    localparam int unsigned CNT_W = $clog2(NMAX + 1);
    localparam int unsigned TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       out_cnt;
    logic [TMR_W-1:0]       timer;
    logic [WIDTH_DOUT-1:0]  tx_shift;

    logic rx_last_c;
    logic tx_fire_c;
    logic tx_last_c;
    logic timer_done_c;

    // Event decodes shared by next-state and datapath logic
    assign rx_last_c    = rx_valid && (byte_cnt == CNT_W'(NIN - 1));
    assign tx_fire_c    = tx_valid && tx_ready;
    assign tx_last_c    = tx_fire_c && (out_cnt == CNT_W'(NOUT - 1));
    assign timer_done_c = (timer == TMR_W'(TIMEOUT));

    // Outgoing byte is always the top byte of the response shift register
    assign tx_byte = tx_shift[WIDTH_DOUT-1 -: 8];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_valid) state_d = LOAD;
            LOAD:    if (rx_last_c) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (cp_dout_valid) begin
                    state_d = SEND;
                end else if (timer_done_c) begin
                    state_d = IDLE;
                end
            end
            SEND:    if (tx_last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath; status strobes follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cp_din       <= '0;
            cp_din_valid <= 1'b0;
            cp_control   <= '0;
            tx_valid     <= 1'b0;
            tx_shift     <= '0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_drop     <= 1'b0;
            byte_cnt     <= '0;
            out_cnt      <= '0;
            timer        <= '0;
        end else begin
            cp_din_valid <= (state_d == ISSUE);
            tx_valid     <= (state_d == SEND);
            busy         <= (state_d != IDLE);

            // A byte arriving while a frame is in flight is never a command
            if (rx_valid && (state_q == ISSUE || state_q == WAIT || state_q == SEND)) begin
                err_drop <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        cp_control  <= rx_byte[5:0];
                        err_timeout <= 1'b0;
                        err_drop    <= 1'b0;
                        byte_cnt    <= '0;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        cp_din   <= (cp_din << 8) | WIDTH_DIN'(rx_byte);
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (cp_dout_valid) begin
                        tx_shift <= cp_dout;
                        out_cnt  <= '0;
                    end else if (timer_done_c) begin
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                SEND: begin
                    if (tx_fire_c) begin
                        tx_shift <= tx_shift << 8;
                        out_cnt  <= out_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
